// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin encoding, denominations, dispenser states
// and the greedy coin-selection helpers.
package vm_pkg;

  // coin_sel encoding presented to the coin ejector
  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_2  = 2'd1;
  localparam logic [1:0] COIN_5  = 2'd2;
  localparam logic [1:0] COIN_10 = 2'd3;

  // Denomination values in units
  localparam logic [3:0] DENOM_1  = 4'd1;
  localparam logic [3:0] DENOM_2  = 4'd2;
  localparam logic [3:0] DENOM_5  = 4'd5;
  localparam logic [3:0] DENOM_10 = 4'd10;

  // Largest legal BCD digit
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPresent,
    StGap,
    StDone
  } disp_state_e;

  // Greedy pick for a remaining tens/ones amount
  function automatic logic [1:0] coin_pick_sel(input logic [3:0] tens, input logic [3:0] ones);
    logic [1:0] sel;
    if (tens != 4'd0) begin
      sel = COIN_10;
    end else if (ones >= DENOM_5) begin
      sel = COIN_5;
    end else if (ones >= DENOM_2) begin
      sel = COIN_2;
    end else begin
      sel = COIN_1;
    end
    return sel;
  endfunction

  // Value taken from the ones digit by a sub-ten coin
  function automatic logic [3:0] coin_ones_value(input logic [1:0] sel);
    logic [3:0] val;
    case (sel)
      COIN_5:  val = DENOM_5;
      COIN_2:  val = DENOM_2;
      default: val = DENOM_1;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/change_coin_pick.sv
// Combinational greedy coin picker: chooses the next coin for the remaining amount
// and reports the amount left once that coin is paid.
module change_coin_pick
  import vm_pkg::*;
(
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  output logic [1:0] coin_sel_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       last_coin_o
);

  // Pick the coin and deduct it from the matching digit
  always_comb begin
    logic [1:0] sel;
    logic [3:0] val;
    sel    = coin_pick_sel(tens_i, ones_i);
    val    = coin_ones_value(sel);
    tens_o = tens_i;
    ones_o = ones_i;
    if (sel == COIN_10) begin
      tens_o = tens_i - 4'd1;
    end else if (ones_i >= val) begin
      // Guard keeps an empty amount at zero instead of wrapping
      ones_o = ones_i - val;
    end
    coin_sel_o  = sel;
    last_coin_o = (tens_o == 4'd0) && (ones_o == 4'd0);
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a 2-digit BCD change amount as a stream of 10/5/2/1 coins, one per
// valid/ready handshake, with an optional idle gap between coins.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned DISPENSE_GAP = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] change_tens_i,
  input  logic [3:0] change_ones_i,
  input  logic       coin_ready_i,
  output logic       coin_valid_o,
  output logic [1:0] coin_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] coin_count_o
);

  localparam int unsigned GapW    = (DISPENSE_GAP > 1) ? $clog2(DISPENSE_GAP) : 1;
  localparam int unsigned GapLast = (DISPENSE_GAP > 0) ? DISPENSE_GAP - 1 : 0;

  disp_state_e state_q, state_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic            coin_valid_q, coin_valid_d;
  logic [1:0]      coin_sel_q, coin_sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [3:0]      coin_count_q, coin_count_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic [1:0] pick_sel;
  logic [3:0] pick_tens;
  logic [3:0] pick_ones;
  logic       pick_last;
  logic [1:0] follow_sel;
  logic       digits_bad;
  logic       amount_zero;

  change_coin_pick u_pick (
    .tens_i      (tens_q),
    .ones_i      (ones_q),
    .coin_sel_o  (pick_sel),
    .tens_o      (pick_tens),
    .ones_o      (pick_ones),
    .last_coin_o (pick_last)
  );

  // Coin after the one currently presented, for back-to-back issue
  assign follow_sel  = coin_pick_sel(pick_tens, pick_ones);
  assign digits_bad  = (change_tens_i > BCD_MAX) || (change_ones_i > BCD_MAX);
  assign amount_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Next-state and registered-output logic for the payout FSM
  always_comb begin
    state_d      = state_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    coin_valid_d = coin_valid_q;
    coin_sel_d   = coin_sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    coin_count_d = coin_count_q;
    gap_cnt_d    = gap_cnt_q;

    unique case (state_q)
      StIdle: begin
        busy_d       = 1'b0;
        coin_valid_d = 1'b0;
        if (start_i) begin
          if (digits_bad) begin
            err_d = 1'b1;
          end else begin
            tens_d       = change_tens_i;
            ones_d       = change_ones_i;
            coin_count_d = 4'd0;
            busy_d       = 1'b1;
            state_d      = StLoad;
          end
        end
      end

      StLoad: begin
        if (amount_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          coin_valid_d = 1'b1;
          coin_sel_d   = pick_sel;
          state_d      = StPresent;
        end
      end

      StPresent: begin
        if (coin_valid_q && coin_ready_i) begin
          tens_d       = pick_tens;
          ones_d       = pick_ones;
          coin_count_d = coin_count_q + 4'd1;
          if (pick_last) begin
            // No gap after the final coin
            coin_valid_d = 1'b0;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            state_d      = StDone;
          end else if (DISPENSE_GAP > 0) begin
            coin_valid_d = 1'b0;
            gap_cnt_d    = '0;
            state_d      = StGap;
          end else begin
            coin_valid_d = 1'b1;
            coin_sel_d   = follow_sel;
          end
        end
      end

      StGap: begin
        if (gap_cnt_q == GapW'(GapLast)) begin
          coin_valid_d = 1'b1;
          coin_sel_d   = pick_sel;
          state_d      = StPresent;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        coin_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      coin_valid_q <= 1'b0;
      coin_sel_q   <= COIN_1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      coin_count_q <= 4'd0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      coin_valid_q <= coin_valid_d;
      coin_sel_q   <= coin_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      coin_count_q <= coin_count_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign coin_valid_o = coin_valid_q;
  assign coin_sel_o   = coin_sel_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign coin_count_o = coin_count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with back-to-back coins, one with
// a two-cycle gap between coins.
module tb_change_dispenser;

  localparam logic [1:0] C1  = 2'd0;
  localparam logic [1:0] C2  = 2'd1;
  localparam logic [1:0] C5  = 2'd2;
  localparam logic [1:0] C10 = 2'd3;

  logic clk = 1'b0;
  logic rst;

  logic       start0, ready0;
  logic [3:0] tens0, ones0;
  logic       v0, busy0, done0, err0;
  logic [1:0] sel0;
  logic [3:0] cnt0;

  logic       start2, ready2;
  logic [3:0] tens2, ones2;
  logic       v2, busy2, done2, err2;
  logic [1:0] sel2;
  logic [3:0] cnt2;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  change_dispenser #(.DISPENSE_GAP(0)) u_dut0 (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start0),
    .change_tens_i (tens0),
    .change_ones_i (ones0),
    .coin_ready_i  (ready0),
    .coin_valid_o  (v0),
    .coin_sel_o    (sel0),
    .busy_o        (busy0),
    .done_o        (done0),
    .err_o         (err0),
    .coin_count_o  (cnt0)
  );

  change_dispenser #(.DISPENSE_GAP(2)) u_dut2 (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start2),
    .change_tens_i (tens2),
    .change_ones_i (ones2),
    .coin_ready_i  (ready2),
    .coin_valid_o  (v2),
    .coin_sel_o    (sel2),
    .busy_o        (busy2),
    .done_o        (done2),
    .err_o         (err2),
    .coin_count_o  (cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] seq37[5];
    logic [1:0] seq99[12];
    logic [1:0] seq48[7];
    seq37 = '{C10, C10, C10, C5, C2};
    seq99 = '{C10, C10, C10, C10, C10, C10, C10, C10, C10, C5, C2, C2};
    seq48 = '{C10, C10, C10, C10, C5, C2, C1};

    rst = 1'b1;
    start0 = 1'b0; ready0 = 1'b0; tens0 = 4'd0; ones0 = 4'd0;
    start2 = 1'b0; ready2 = 1'b0; tens2 = 4'd0; ones2 = 4'd0;
    tick();
    tick();
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_sel", 32'(sel0), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    tick();

    // 37 back-to-back with ready tied high
    start0 = 1'b1; tens0 = 4'd3; ones0 = 4'd7; ready0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("a37_load_busy", 32'(busy0), 32'd1);
    check("a37_load_valid", 32'(v0), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("a37_valid%0d", i), 32'(v0), 32'd1);
      check($sformatf("a37_sel%0d", i), 32'(sel0), 32'(seq37[i]));
      tick();
    end
    check("a37_done", 32'(done0), 32'd1);
    check("a37_busy_done", 32'(busy0), 32'd0);
    check("a37_valid_done", 32'(v0), 32'd0);
    check("a37_count", 32'(cnt0), 32'd5);
    tick();
    check("a37_done_pulse", 32'(done0), 32'd0);

    // Non-BCD tens digit is rejected
    start0 = 1'b1; tens0 = 4'hA; ones0 = 4'd3;
    tick();
    start0 = 1'b0;
    check("bad_err", 32'(err0), 32'd1);
    check("bad_busy", 32'(busy0), 32'd0);
    check("bad_count_kept", 32'(cnt0), 32'd5);
    tick();
    check("bad_err_pulse", 32'(err0), 32'd0);
    check("bad_valid", 32'(v0), 32'd0);
    check("bad_busy2", 32'(busy0), 32'd0);

    // Amount 00: done two edges after start, no coin
    start0 = 1'b1; tens0 = 4'd0; ones0 = 4'd0;
    tick();
    start0 = 1'b0;
    check("z_busy", 32'(busy0), 32'd1);
    check("z_done_early", 32'(done0), 32'd0);
    tick();
    check("z_done", 32'(done0), 32'd1);
    check("z_valid", 32'(v0), 32'd0);
    check("z_count", 32'(cnt0), 32'd0);
    tick();
    check("z_done_pulse", 32'(done0), 32'd0);
    check("z_valid2", 32'(v0), 32'd0);

    // Amount 06 with backpressure
    ready0 = 1'b0;
    start0 = 1'b1; tens0 = 4'd0; ones0 = 4'd6;
    tick();
    start0 = 1'b0;
    tick();
    check("bp_valid", 32'(v0), 32'd1);
    check("bp_sel", 32'(sel0), 32'(C5));
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), 32'(v0), 32'd1);
      check($sformatf("bp_hold_sel%0d", i), 32'(sel0), 32'(C5));
    end
    check("bp_hold_count", 32'(cnt0), 32'd0);
    ready0 = 1'b1;
    tick();
    check("bp_next_valid", 32'(v0), 32'd1);
    check("bp_next_sel", 32'(sel0), 32'(C1));
    check("bp_next_count", 32'(cnt0), 32'd1);
    tick();
    check("bp_done", 32'(done0), 32'd1);
    check("bp_count", 32'(cnt0), 32'd2);
    tick();

    // Amount 48 with a second start while busy
    start0 = 1'b1; tens0 = 4'd4; ones0 = 4'd8;
    tick();
    tens0 = 4'd1; ones0 = 4'd1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("a48_valid%0d", i), 32'(v0), 32'd1);
      check($sformatf("a48_sel%0d", i), 32'(sel0), 32'(seq48[i]));
      tick();
    end
    check("a48_done", 32'(done0), 32'd1);
    check("a48_count", 32'(cnt0), 32'd7);
    tick();
    check("a48_idle_valid", 32'(v0), 32'd0);
    check("a48_idle_busy", 32'(busy0), 32'd0);
    tick();
    check("a48_idle_busy2", 32'(busy0), 32'd0);

    // Amount 48 again, reset during the third coin
    start0 = 1'b1; tens0 = 4'd4; ones0 = 4'd8;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    check("rst3_sel", 32'(sel0), 32'(C10));
    check("rst3_count", 32'(cnt0), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst3_valid", 32'(v0), 32'd0);
    check("rst3_busy", 32'(busy0), 32'd0);
    check("rst3_done", 32'(done0), 32'd0);
    check("rst3_count0", 32'(cnt0), 32'd0);
    tick();
    check("rst3_no_done", 32'(done0), 32'd0);
    check("rst3_no_valid", 32'(v0), 32'd0);

    // Fresh 02 after reset
    start0 = 1'b1; tens0 = 4'd0; ones0 = 4'd2;
    tick();
    start0 = 1'b0;
    tick();
    check("a02_valid", 32'(v0), 32'd1);
    check("a02_sel", 32'(sel0), 32'(C2));
    tick();
    check("a02_done", 32'(done0), 32'd1);
    check("a02_valid_off", 32'(v0), 32'd0);
    check("a02_count", 32'(cnt0), 32'd1);
    tick();

    // 99 on the gap-2 instance
    start2 = 1'b1; tens2 = 4'd9; ones2 = 4'd9; ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("g99_valid%0d", i), 32'(v2), 32'd1);
      check($sformatf("g99_sel%0d", i), 32'(sel2), 32'(seq99[i]));
      tick();
      if (i < 11) begin
        check($sformatf("g99_gapa%0d", i), 32'(v2), 32'd0);
        check($sformatf("g99_gapbusy%0d", i), 32'(busy2), 32'd1);
        tick();
        check($sformatf("g99_gapb%0d", i), 32'(v2), 32'd0);
        tick();
      end
    end
    check("g99_done", 32'(done2), 32'd1);
    check("g99_valid_off", 32'(v2), 32'd0);
    check("g99_count", 32'(cnt2), 32'd12);
    tick();
    check("g99_done_pulse", 32'(done2), 32'd0);
    check("g99_err", 32'(err2), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the BCD change-subtract stage in the vending machine.
- Takes a 2-digit BCD change amount (0–99 units) and pays it out as a stream of coins.
- Pays greedily with 10, 5, 2 and 1-unit coins, one coin per valid/ready handshake with the coin ejector.
- Reports busy, completion, invalid-input error and the number of coins paid.

Parameters:
- DISPENSE_GAP, default 2: idle cycles inserted after each accepted coin before the next is presented; 0 means back-to-back.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to pay out the change digits; sampled only in IDLE.
- change_tens  in  4  BCD tens digit of the change amount.
- change_ones  in  4  BCD ones digit of the change amount.
- coin_ready  in  1  ejector accepts the presented coin this cycle.
- coin_valid  out  1  a coin is being presented.
- coin_sel  out  2  denomination of the presented coin (package encoding).
- busy  out  1  transaction in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  one-cycle pulse when start is rejected for a non-BCD digit.
- coin_count  out  4  coins accepted in the current or last transaction; max 12 (amount 99).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - coin_valid, done, err, busy = 0.
  - coin_sel = 0, coin_count = 0; internal remaining digits = 0.
- Reset mid-transaction: at the next clk edge with rst=1, all of the above apply. coin_valid drops at that edge, the remaining amount is discarded and no done pulse is issued.
- All outputs are registered.
- States: IDLE, LOAD, PRESENT, GAP, DONE.
- IDLE:
  - start=1 with both digits ≤ 9 → LOAD; capture digits and clear coin_count.
  - start=1 with either digit > 9 → stay in IDLE; err=1 for exactly one cycle; coin_count unchanged.
- LOAD: one cycle.
  - Remaining amount 0 → DONE.
  - Otherwise → PRESENT, with coin_valid=1 and coin_sel = greedy pick.
- Greedy pick, in priority order:
  - tens > 0 → COIN_10.
  - else ones ≥ 5 → COIN_5.
  - else ones ≥ 2 → COIN_2.
  - else → COIN_1.
- PRESENT:
  - coin_valid and coin_sel are held stable until coin_ready=1.
  - On coin_valid & coin_ready:
    - Decrement tens by 1, or subtract 5/2/1 from ones.
    - coin_count += 1; coin_valid drops at the same edge.
  - Next state after an accepted coin:
    - Remaining amount 0 → DONE; the gap is skipped after the last coin.
    - Else DISPENSE_GAP > 0 → GAP.
    - Else → stay in PRESENT with the next pick and coin_valid=1 at the following edge, so back-to-back coins issue 1 per cycle.
- GAP: counts DISPENSE_GAP cycles with coin_valid=0, then → PRESENT with the next pick.
- DONE: done=1 for one cycle, busy=0, → IDLE. coin_count holds until the next accepted start.
- start while busy is ignored (no capture, no err). Digit inputs are don't-care outside the IDLE start cycle.
- coin_ready while coin_valid=0 has no effect.
- Latency, no backpressure, DISPENSE_GAP=0:
  - First coin_valid visible 2 edges after start is sampled.
  - Amount 00 gives done 2 edges after start.
- Width rules:
  - Ones-digit arithmetic is 4-bit unsigned and never underflows, because the pick guarantees ones ≥ coin value.
  - coin_count is 4 bits and never exceeds 12.

Decomposition:
- Shared package vm_pkg:
  - coin_sel encoding COIN_1=2'd0, COIN_2=2'd1, COIN_5=2'd2, COIN_10=2'd3.
  - Denomination constants 1, 2, 5, 10.
  - Dispenser state enum.
  - BCD_MAX=9.
- Sub-module change_coin_pick (combinational): remaining tens/ones → coin_sel, next tens, next ones, last_coin flag.
- The FSM, gap counter and handshake stay in change_dispenser.

Test Plan:
- Tens=3, ones=7, ready tied 1, DISPENSE_GAP=0 → coin_sel sequence 10,10,10,5,2 on 5 consecutive cycles; done pulses once; coin_count=5.
- Tens=9, ones=9, ready tied 1, DISPENSE_GAP=2 → 9×COIN_10, COIN_5, COIN_2, COIN_2, with exactly 2 idle cycles between coins; coin_count=12; done 1 cycle.
- Tens=0, ones=0 → no coin_valid ever; done pulses 2 edges after start; coin_count=0. Tens=0xA, ones=3 → err 1 cycle, busy stays 0, no coin_valid.
- Amount 06, coin_ready held 0 for 5 cycles while coin_valid=1 → coin_sel stays COIN_5 unchanged; then ready=1 → COIN_1 presented, then done.
- Amount 48, second start pulse issued while busy → ignored; output is 10,10,10,10,5,2,1 only. Assert rst during the third coin → coin_valid=0, busy=0, no done; a fresh start of 02 then yields a single COIN_2.
